// File: rtl/fp_addsub.sv
// Multi-cycle sign/exponent/fraction floating-point adder/subtractor.
// One operation in flight; result and flags hold until the next completion.
module fp_addsub #(
    parameter int EXP_W  = 3,
    parameter int FRAC_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  sub,
    input  logic [EXP_W+FRAC_W:0] op1,
    input  logic [EXP_W+FRAC_W:0] op2,
    output logic [EXP_W+FRAC_W:0] res,
    output logic                  done,
    output logic                  busy,
    output logic                  ovf,
    output logic                  unf,
    output logic                  zero
);

    localparam int W    = 1 + EXP_W + FRAC_W;
    localparam int EMAX = 2**EXP_W - 1;
    localparam int MW   = FRAC_W + 4;
    localparam int EW   = EXP_W + $clog2(FRAC_W + 3) + 2;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

    state_t               state_q, state_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic [EXP_W-1:0]     ea_q, ea_d, eb_q, eb_d;
    logic [FRAC_W-1:0]    fa_q, fa_d, fb_q, fb_d;
    logic [MW-1:0]        ma_q, ma_d, mb_q, mb_d, mant_q, mant_d;
    logic                 sign_q, sign_d;
    logic signed [EW-1:0] ebuf_q, ebuf_d;
    logic [W-1:0]         res_q, res_d;
    logic                 done_q, done_d, busy_q, busy_d;
    logic                 ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;

    logic                 accept, carry, hidden, mantNz;
    logic [MW-1:0]        alA, alB;
    logic [EXP_W-1:0]     exA, exB, diff;

    // A start coinciding with the done pulse is left for the following idle cycle.
    assign accept = (state_q == IDLE) && start && !done_q;
    assign carry  = mant_q[MW-1];
    assign hidden = mant_q[MW-2];
    assign mantNz = |mant_q;

    // A zero operand contributes no mantissa and borrows the other exponent.
    always_comb begin
        alA  = (ea_q == '0) ? '0 : {2'b01, fa_q, 2'b00};
        alB  = (eb_q == '0) ? '0 : {2'b01, fb_q, 2'b00};
        exA  = (ea_q == '0) ? eb_q : ea_q;
        exB  = (eb_q == '0) ? ea_q : eb_q;
        diff = (exA >= exB) ? (exA - exB) : (exB - exA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    if (carry || hidden || !mantNz) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sa_d = sa_q;   sb_d = sb_q;   ea_d = ea_q;     eb_d = eb_q;
        fa_d = fa_q;   fb_d = fb_q;   ma_d = ma_q;     mb_d = mb_q;
        mant_d = mant_q; sign_d = sign_q; ebuf_d = ebuf_q; res_d = res_q;
        done_d = 1'b0; busy_d = busy_q;
        ovf_d = ovf_q; unf_d = unf_q; zero_d = zero_q;
        case (state_q)
            IDLE: if (accept) begin
                sa_d   = op1[W-1];
                ea_d   = op1[W-2:FRAC_W];
                fa_d   = op1[FRAC_W-1:0];
                sb_d   = op2[W-1] ^ sub;
                eb_d   = op2[W-2:FRAC_W];
                fb_d   = op2[FRAC_W-1:0];
                busy_d = 1'b1;
                ovf_d  = 1'b0;
                unf_d  = 1'b0;
                zero_d = 1'b0;
            end
            ALIGN: begin
                if (exA >= exB) begin
                    ma_d   = alA;
                    mb_d   = (32'(diff) >= FRAC_W + 3) ? '0 : (alB >> diff);
                    ebuf_d = EW'(exA);
                end else begin
                    ma_d   = (32'(diff) >= FRAC_W + 3) ? '0 : (alA >> diff);
                    mb_d   = alB;
                    ebuf_d = EW'(exB);
                end
            end
            ADD: begin
                if (sa_q == sb_q) begin
                    mant_d = ma_q + mb_q;
                    sign_d = sa_q;
                end else if (ma_q > mb_q) begin
                    mant_d = ma_q - mb_q;
                    sign_d = sa_q;
                end else if (mb_q > ma_q) begin
                    mant_d = mb_q - ma_q;
                    sign_d = sb_q;
                end else begin
                    mant_d = '0;
                    sign_d = 1'b0;
                end
            end
            NORM: begin
                if (carry) begin
                    mant_d = mant_q >> 1;
                    ebuf_d = ebuf_q + EW'(1);
                end else if (!hidden && mantNz) begin
                    mant_d = mant_q << 1;
                    ebuf_d = ebuf_q - EW'(1);
                end
            end
            OUT: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                if (!mantNz) begin
                    res_d  = '0;
                    zero_d = 1'b1;
                end else if (ebuf_q > EW'(EMAX)) begin
                    res_d = {sign_q, {(W-1){1'b1}}};
                    ovf_d = 1'b1;
                end else if (ebuf_q < EW'(1)) begin
                    res_d  = '0;
                    unf_d  = 1'b1;
                    zero_d = 1'b1;
                end else begin
                    res_d = {sign_q, ebuf_q[EXP_W-1:0], mant_q[FRAC_W+1:2]};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q <= 1'b0;  sb_q <= 1'b0;  ea_q <= '0;  eb_q <= '0;
            fa_q <= '0;    fb_q <= '0;    ma_q <= '0;  mb_q <= '0;
            mant_q <= '0;  sign_q <= 1'b0; ebuf_q <= '0; res_q <= '0;
            done_q <= 1'b0; busy_q <= 1'b0;
            ovf_q <= 1'b0; unf_q <= 1'b0; zero_q <= 1'b0;
        end else begin
            sa_q <= sa_d;  sb_q <= sb_d;  ea_q <= ea_d;  eb_q <= eb_d;
            fa_q <= fa_d;  fb_q <= fb_d;  ma_q <= ma_d;  mb_q <= mb_d;
            mant_q <= mant_d; sign_q <= sign_d; ebuf_q <= ebuf_d; res_q <= res_d;
            done_q <= done_d; busy_q <= busy_d;
            ovf_q <= ovf_d; unf_q <= unf_d; zero_q <= zero_d;
        end
    end

    assign res  = res_q;
    assign done = done_q;
    assign busy = busy_q;
    assign ovf  = ovf_q;
    assign unf  = unf_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_fp_addsub.sv
// Self-checking bench for fp_addsub: directed cases on an 8-bit instance,
// randomized operands on both an 8-bit and a 16-bit instance against a value model.
module tb_fp_addsub;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       nStart, nSub, nDone, nBusy, nOvf, nUnf, nZero;
    logic [7:0] nOp1, nOp2, nRes;
    logic       wStart, wSub, wDone, wBusy, wOvf, wUnf, wZero;
    logic [15:0] wOp1, wOp2, wRes;

    int total = 0;
    int bad   = 0;

    fp_addsub #(.EXP_W(3), .FRAC_W(4)) dutN (
        .clk(clk), .rst_n(rst_n), .start(nStart), .sub(nSub),
        .op1(nOp1), .op2(nOp2), .res(nRes), .done(nDone),
        .busy(nBusy), .ovf(nOvf), .unf(nUnf), .zero(nZero)
    );

    fp_addsub #(.EXP_W(5), .FRAC_W(10)) dutW (
        .clk(clk), .rst_n(rst_n), .start(wStart), .sub(wSub),
        .op1(wOp1), .op2(wOp2), .res(wRes), .done(wDone),
        .busy(wBusy), .ovf(wOvf), .unf(wUnf), .zero(wZero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached before the end of the run");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Value-level model: exact signed sum of the operands on the grid of the
    // larger exponent (two bits below the fraction), then truncate to FRAC_W bits.
    function automatic void refModel(input int ew, input int fw, input longint a, input longint b,
                                     input bit s, output longint r, output int flags, output int lat);
        longint emax, fmask, ma, mb, sum, mag, frac;
        int     ea, eb, ebig, p, e;
        bit     sa, sb, sg;
        emax  = (longint'(1) << ew) - 1;
        fmask = (longint'(1) << fw) - 1;
        sa = a[ew+fw];
        sb = b[ew+fw] ^ s;
        ea = int'((a >> fw) & emax);
        eb = int'((b >> fw) & emax);
        ma = (ea == 0) ? 0 : (((fmask + 1) | (a & fmask)) << 2);
        mb = (eb == 0) ? 0 : (((fmask + 1) | (b & fmask)) << 2);
        if (ea == 0) ea = eb;
        else if (eb == 0) eb = ea;
        ebig = (ea > eb) ? ea : eb;
        ma = (ebig - ea >= fw + 3) ? 0 : (ma >> (ebig - ea));
        mb = (ebig - eb >= fw + 3) ? 0 : (mb >> (ebig - eb));
        sum = (sa ? -ma : ma) + (sb ? -mb : mb);
        sg  = (sum < 0);
        mag = sg ? -sum : sum;
        lat = 4;
        flags = 0;
        if (mag == 0) begin
            r = 0;
            flags = 1;
            return;
        end
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        e = ebig + p - (fw + 2);
        if (p < fw + 2) lat = 4 + (fw + 2 - p);
        frac = ((p >= fw) ? (mag >> (p - fw)) : (mag << (fw - p))) & fmask;
        if (e > emax) begin
            r = (longint'(sg) << (ew + fw)) | ((longint'(1) << (ew + fw)) - 1);
            flags = 4;
        end else if (e < 1) begin
            r = 0;
            flags = 3;
        end else begin
            r = (longint'(sg) << (ew + fw)) | (longint'(e) << fw) | frac;
        end
    endfunction

    function automatic longint randOp(input int ew, input int fw, input longint other);
        longint v, emax, fmask;
        emax  = (longint'(1) << ew) - 1;
        fmask = (longint'(1) << fw) - 1;
        v = longint'($urandom) & ((longint'(1) << (1 + ew + fw)) - 1);
        if ($urandom_range(0, 2) == 0)
            v = (v & ~(emax << fw)) | (other & (emax << fw));
        if ($urandom_range(0, 15) == 0)
            v = v & ~(emax << fw);
        v = v & ((longint'(1) << (1 + ew + fw)) - 1);
        if (fmask == 0) v = 0;
        return v;
    endfunction

    task automatic applyStimulus(input bit wide, input string tag, input longint a, input longint b,
                                 input bit s, output longint r, output int flags, output int lat);
        bit got;
        int guard;
        @(negedge clk);
        guard = 0;
        while ((wide ? wDone : nDone) && guard < 5) begin
            @(negedge clk);
            guard++;
        end
        if (wide) begin
            wOp1 = a[15:0]; wOp2 = b[15:0]; wSub = s; wStart = 1'b1;
        end else begin
            nOp1 = a[7:0];  nOp2 = b[7:0];  nSub = s; nStart = 1'b1;
        end
        @(posedge clk);
        #1;
        if (wide) begin
            wStart = 1'b0; wOp1 = 16'($urandom); wOp2 = 16'($urandom); wSub = ~s;
        end else begin
            nStart = 1'b0; nOp1 = 8'($urandom);  nOp2 = 8'($urandom);  nSub = ~s;
        end
        checkOutput({tag, ".busy"}, longint'(wide ? wBusy : nBusy), 1);
        got = 1'b0;
        lat = 0;
        r = 0;
        flags = 0;
        for (int i = 1; i <= 30 && !got; i++) begin
            @(posedge clk);
            #1;
            if (wide ? wDone : nDone) begin
                got = 1'b1;
                lat = i;
                r = wide ? longint'(wRes) : longint'(nRes);
                flags = wide ? int'({wOvf, wUnf, wZero}) : int'({nOvf, nUnf, nZero});
            end
        end
        checkOutput({tag, ".doneSeen"}, longint'(got), 1);
    endtask

    // Directed cases: operands, sub, expected res, {ovf,unf,zero}, latency.
    longint dA [10] = '{'h30, 'h30, 'h30, 'h7F, 'h30, 'h3F, 'hB0, 'h30, 'h00, 'hFF};
    longint dB [10] = '{'h30, 'h28, 'h30, 'h7F, 'h2E, 'h10, 'h38, 'h00, 'h00, 'hFF};
    bit     dS [10] = '{0, 1, 1, 0, 1, 0, 0, 0, 0, 0};
    longint dR [10] = '{'h40, 'h10, 'h00, 'h7F, 'h00, 'h41, 'h20, 'h30, 'h00, 'hFF};
    int     dF [10] = '{0, 0, 1, 4, 3, 0, 0, 0, 1, 4};
    int     dL [10] = '{4, 6, 4, 4, 8, 4, 5, 4, 4, 4};

    initial begin
        longint r, er, a, b;
        int     f, l, ef, el, nd;
        bit     s;

        rst_n = 1'b0;
        nStart = 1'b0; nSub = 1'b0; nOp1 = '0; nOp2 = '0;
        wStart = 1'b0; wSub = 1'b0; wOp1 = '0; wOp2 = '0;
        #12;
        checkOutput("n.reset", longint'({nRes, nDone, nBusy, nOvf, nUnf, nZero}), 0);
        checkOutput("w.reset", longint'({wRes, wDone, wBusy, wOvf, wUnf, wZero}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, $sformatf("dir%0d", i), dA[i], dB[i], dS[i], r, f, l);
            checkOutput($sformatf("dir%0d.res", i), r, dR[i]);
            checkOutput($sformatf("dir%0d.flags", i), longint'(f), longint'(dF[i]));
            checkOutput($sformatf("dir%0d.latency", i), longint'(l), longint'(dL[i]));
        end

        // Second start while busy must be dropped.
        repeat (3) @(negedge clk);
        nOp1 = 8'h30; nOp2 = 8'h30; nSub = 1'b0; nStart = 1'b1;
        @(negedge clk);
        nStart = 1'b0;
        @(negedge clk);
        nOp1 = 8'h7F; nOp2 = 8'h7F; nStart = 1'b1;
        @(negedge clk);
        nStart = 1'b0;
        nd = 0;
        r = 0;
        repeat (20) begin
            @(negedge clk);
            if (nDone) begin
                nd++;
                r = longint'(nRes);
            end
        end
        checkOutput("busyStart.doneCount", longint'(nd), 1);
        checkOutput("busyStart.res", r, 'h40);

        // Reset in the middle of normalisation.
        nOp1 = 8'h30; nOp2 = 8'h2E; nSub = 1'b1; nStart = 1'b1;
        @(negedge clk);
        nStart = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midReset.busyBefore", longint'(nBusy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("midReset.outputs", longint'({nRes, nDone, nBusy, nOvf, nUnf, nZero}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            if (nDone) nd++;
        end
        checkOutput("midReset.noDone", longint'(nd), 0);
        applyStimulus(1'b0, "afterReset", 'h30, 'h30, 1'b0, r, f, l);
        checkOutput("afterReset.res", r, 'h40);
        checkOutput("afterReset.latency", longint'(l), 4);

        for (int i = 0; i < 150; i++) begin
            a = randOp(3, 4, 0);
            b = randOp(3, 4, a);
            s = 1'($urandom_range(0, 1));
            refModel(3, 4, a, b, s, er, ef, el);
            applyStimulus(1'b0, $sformatf("n%0d", i), a, b, s, r, f, l);
            checkOutput($sformatf("n%0d.res(%0h,%0h,%0d)", i, a, b, s), r, er);
            checkOutput($sformatf("n%0d.flags", i), longint'(f), longint'(ef));
            checkOutput($sformatf("n%0d.latency", i), longint'(l), longint'(el));
        end

        for (int i = 0; i < 250; i++) begin
            a = randOp(5, 10, 0);
            b = randOp(5, 10, a);
            s = 1'($urandom_range(0, 1));
            refModel(5, 10, a, b, s, er, ef, el);
            applyStimulus(1'b1, $sformatf("w%0d", i), a, b, s, r, f, l);
            checkOutput($sformatf("w%0d.res(%0h,%0h,%0d)", i, a, b, s), r, er);
            checkOutput($sformatf("w%0d.flags", i), longint'(f), longint'(ef));
            checkOutput($sformatf("w%0d.latency", i), longint'(l), longint'(el));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_addsub.md
Name: fp_addsub

Overview:
- Parametrised sign/exponent/fraction floating-point adder/subtractor; successor to the fixed 8-bit multi-cycle adder.
- Adds subtract mode, a start/done handshake, correct mixed-sign handling, zero encoding, and overflow/underflow/zero flags.
- Sits in the arithmetic datapath; one operation at a time; multi-cycle FSM.

Parameters:
- EXP_W, 3, exponent field width.
- FRAC_W, 4, stored fraction width; hidden leading 1 implied.
- Derived, not overridable: W = 1+EXP_W+FRAC_W; BIAS = 2^(EXP_W-1)-1; EMAX = 2^EXP_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- sub  in  1  0: op1+op2, 1: op1-op2.
- op1  in  W  operand {sign, exp, frac}.
- op2  in  W  operand {sign, exp, frac}.
- res  out  W  result; held until next done.
- done  out  1  one-cycle pulse; res and flags valid.
- busy  out  1  high from capture edge until done edge.
- ovf  out  1  exponent overflow; res saturated.
- unf  out  1  exponent underflow; res flushed to +0.
- zero  out  1  res is +0.

Behaviour:
- Encoding: value = (-1)^s * 1.f * 2^(e-BIAS). exp field 0 means zero regardless of frac; no inf/NaN/denormals.
- Reset (async, rst_n=0): state IDLE; res=0, done=0, busy=0, ovf=0, unf=0, zero=0; in-flight operation discarded. Release mid-operation returns to IDLE with no done.
- States and transitions:
  - IDLE: start=1 at a rising edge captures op1, op2, sub (op2 sign inverted if sub=1); busy=1; go to ALIGN.
  - ALIGN: internal mantissa {carry, hidden, FRAC_W frac, 2 guard} = FRAC_W+4 bits. Zero operand gets mantissa 0 and exponent equal to the other's. Smaller-exponent mantissa shifted right by the difference in one cycle. Difference >= FRAC_W+3 makes it zero. ebuf = larger exponent. Go to ADD.
  - ADD: same effective sign: add magnitudes, sign = common sign. Otherwise: larger magnitude minus smaller, sign = sign of the larger. Equal magnitudes give exact 0 with sign 0. Go to NORM.
  - NORM:
    - carry=1: shift right 1, ebuf+1, one cycle.
    - Else, hidden=0 and mantissa nonzero: shift left 1, ebuf-1, one cycle per shift, stay in NORM.
    - Else go to OUT.
  - OUT: register res and flags; done=1 for exactly one cycle; busy=0; go to IDLE.
- Flag and result rules at OUT:
  - Mantissa 0: res=0, zero=1.
  - ebuf > EMAX: res = {sign, all-ones exp, all-ones frac}, ovf=1.
  - ebuf < 1 (signed tracking; never wraps): res=0, unf=1, zero=1.
  - Otherwise res = {sign, ebuf, frac bits below hidden}; guard bits truncated toward zero.
- Latency: done on the 4th rising edge after the capture edge, plus one edge per NORM shift. Maximum is 4+FRAC_W+2.
- start while busy=1 is ignored (no queue). start in the same cycle as done is not accepted; it is sampled again in IDLE.
- Inputs are sampled only at the capture edge; later changes have no effect.
- Flags are cleared at each capture; res holds its previous value until the next OUT.

Test Plan (default EXP_W=3, FRAC_W=4):
- op1=0x30, op2=0x30, sub=0 -> res=0x40, flags 0, done 4 edges after capture.
- 0x30 - 0x28 (1.0-0.75) -> res=0x10, two NORM shifts, done 6 edges after capture.
- 0x30 - 0x30 -> res=0x00, zero=1. 0x7F + 0x7F -> res=0x7F, ovf=1. 0x30 - 0x2E -> res=0x00, unf=1, zero=1.
- 0x3F + 0x10 -> res=0x41 (truncation). 0xB0 + 0x38 -> res=0x20. 0x30 + 0x00 -> res=0x30.
- start pulsed while busy -> ignored, single done. rst_n low during NORM -> outputs 0, no done; next start completes normally.
- Sweep EXP_W=5, FRAC_W=10 against a reference model (truncating, saturating) on random operands -> bit-exact res and flags.
